exec_cc_stage: RTL and testbench

- Execute-stage back end that sits directly downstream of the 64-bit ALU (control 00 add, 01 sub, 10 and, 11 xor; outputs Z and ovf).
- Holds the Y86 condition-code register (ZF/SF/OF) and derives flags from the ALU result.
- Evaluates the jXX/cmovXX condition from the current CC.
- Registers valE, cnd and valid into the execute-to-memory pipeline register, with stall, bubble and exception-suppression control.

---
 rtl/y86_pkg.sv | 20 ++
 rtl/exec_cc_stage_cond_eval.sv | 39 +++
 rtl/exec_cc_stage.sv | 106 ++++++++++
 tb/tb_exec_cc_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage constants: datapath width, ALU function codes,
// and jXX/cmovXX condition function codes.
package y86_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

endpackage

// File: rtl/exec_cc_stage_cond_eval.sv
// cond_eval: purely combinational Y86 condition evaluator, shared with the
// fetch-side branch-prediction checker.
// Ports:
//   zf, sf, of : condition-code flags to evaluate against
//   ifun       : condition function code
//   cnd        : condition result (0 for undefined codes)
//   bad        : ifun is not a defined condition code
module cond_eval
  import y86_pkg::*;
(
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad
);

  logic lt;

  // Signed less-than from the flags of the preceding compare/arith op.
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    bad = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: execute-stage back end downstream of the ALU. Holds the Y86
// condition-code register, evaluates jXX/cmovXX conditions from the current
// CC, and registers valE/cnd/valid into the execute-to-memory register.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   alu_valid         : instruction present in execute
//   alu_fn            : ALU op (add/sub/and/xor)
//   alu_z, alu_ovf    : ALU result and signed-overflow flag
//   set_cc            : instruction is OPq and may write CC
//   ifun              : condition function code
//   suppress          : later stage has a non-AOK status; blocks CC write
//   stall, bubble     : pipeline-register hold / NOP injection
//   e_cnd, cond_err   : combinational condition and undefined-code error
//   cc_zf/sf/of       : registered condition codes
//   m_valid/valE/cnd  : registered execute-to-memory payload
module exec_cc_stage
  import y86_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alu_valid,
  input  logic [1:0]   alu_fn,
  input  logic [W-1:0] alu_z,
  input  logic         alu_ovf,
  input  logic         set_cc,
  input  logic [3:0]   ifun,
  input  logic         suppress,
  input  logic         stall,
  input  logic         bubble,
  output logic         e_cnd,
  output logic         cond_err,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         m_valid,
  output logic [W-1:0] m_valE,
  output logic         m_cnd
);

  logic new_zf;
  logic new_sf;
  logic new_of;
  logic cc_we;
  logic cnd_bad;

  // Flags from the ALU result; logical ops never report overflow.
  always_comb begin
    new_zf = (alu_z == '0);
    new_sf = alu_z[W-1];
    new_of = 1'b0;
    if ((alu_fn == ALU_ADD) || (alu_fn == ALU_SUB)) begin
      new_of = alu_ovf;
    end
  end

  assign cc_we = alu_valid & set_cc & ~suppress & ~stall;

  // Condition uses the pre-update CC: no bypass from the new flags.
  cond_eval u_cond_eval (
    .zf   (cc_zf),
    .sf   (cc_sf),
    .of   (cc_of),
    .ifun (ifun),
    .cnd  (e_cnd),
    .bad  (cnd_bad)
  );

  assign cond_err = alu_valid & cnd_bad;

  // Condition-code register; resets to "equal" (ZF=1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (cc_we) begin
      cc_zf <= new_zf;
      cc_sf <= new_sf;
      cc_of <= new_of;
    end
  end

  // Execute-to-memory register: stall holds, then bubble clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_valE  <= '0;
      m_cnd   <= 1'b0;
    end else if (stall) begin
      m_valid <= m_valid;
      m_valE  <= m_valE;
      m_cnd   <= m_cnd;
    end else if (bubble) begin
      m_valid <= 1'b0;
      m_valE  <= '0;
      m_cnd   <= 1'b0;
    end else begin
      m_valid <= alu_valid;
      m_valE  <= alu_z;
      m_cnd   <= e_cnd & alu_valid;
    end
  end

endmodule

// File: tb/tb_exec_cc_stage.sv
// Scoreboard bench for exec_cc_stage: stimulus pushes hand-computed
// expectations, a monitor pops and compares them against the DUT.
module tb_exec_cc_stage;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic         alu_valid;
  logic [1:0]   alu_fn;
  logic [W-1:0] alu_z;
  logic         alu_ovf;
  logic         set_cc;
  logic [3:0]   ifun;
  logic         suppress;
  logic         stall;
  logic         bubble;
  logic         e_cnd;
  logic         cond_err;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;
  logic         m_valid;
  logic [W-1:0] m_valE;
  logic         m_cnd;

  exec_cc_stage #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_fn    (alu_fn),
    .alu_z     (alu_z),
    .alu_ovf   (alu_ovf),
    .set_cc    (set_cc),
    .ifun      (ifun),
    .suppress  (suppress),
    .stall     (stall),
    .bubble    (bubble),
    .e_cnd     (e_cnd),
    .cond_err  (cond_err),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .m_valid   (m_valid),
    .m_valE    (m_valE),
    .m_cnd     (m_cnd)
  );

  typedef struct {
    string        name;
    bit           full;
    logic         ec;
    logic         er;
    logic         zf;
    logic         sf;
    logic         of;
    logic         mv;
    logic [W-1:0] ve;
    logic         mc;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  task automatic chk_regs(input exp_t e);
    chk(e.name, "cc_zf",   W'(cc_zf),   W'(e.zf));
    chk(e.name, "cc_sf",   W'(cc_sf),   W'(e.sf));
    chk(e.name, "cc_of",   W'(cc_of),   W'(e.of));
    chk(e.name, "m_valid", W'(m_valid), W'(e.mv));
    chk(e.name, "m_valE",  m_valE,      e.ve);
    chk(e.name, "m_cnd",   W'(m_cnd),   W'(e.mc));
  endtask

  // Monitor: registered outputs after each rising edge, combinational
  // outputs mid low phase once the stimulus has settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        chk_regs(e);
      end
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        chk(e.name, "e_cnd",    W'(e_cnd),    W'(e.ec));
        chk(e.name, "cond_err", W'(cond_err), W'(e.er));
        if (e.full) chk_regs(e);
      end
      if (done && comb_q.size() == 0 && reg_q.size() == 0) break;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [1:0] fn, input logic [W-1:0] z,
                       input logic ovf, input logic sc, input logic [3:0] ifn,
                       input logic sup, input logic st, input logic bb);
    alu_valid = v;
    alu_fn    = fn;
    alu_z     = z;
    alu_ovf   = ovf;
    set_cc    = sc;
    ifun      = ifn;
    suppress  = sup;
    stall     = st;
    bubble    = bb;
  endtask

  task automatic push_full(input string nm, input logic ec, input logic er);
    exp_t e;
    e.name = nm; e.full = 1'b1; e.ec = ec; e.er = er;
    e.zf = 1'b1; e.sf = 1'b0; e.of = 1'b0;
    e.mv = 1'b0; e.ve = '0; e.mc = 1'b0;
    comb_q.push_back(e);
  endtask

  // One execute cycle: apply inputs, expect combinational outputs now and
  // the CC / M-register state after the next rising edge.
  task automatic step(input string nm, input logic v, input logic [1:0] fn,
                      input logic [W-1:0] z, input logic ovf, input logic sc,
                      input logic [3:0] ifn, input logic sup, input logic st,
                      input logic bb, input logic ec, input logic er,
                      input logic zf, input logic sf, input logic of,
                      input logic mv, input logic [W-1:0] ve, input logic mc);
    exp_t e;
    drive(v, fn, z, ovf, sc, ifn, sup, st, bb);
    e.name = nm; e.full = 1'b0; e.ec = ec; e.er = er;
    e.zf = zf; e.sf = sf; e.of = of; e.mv = mv; e.ve = ve; e.mc = mc;
    comb_q.push_back(e);
    reg_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    push_full("reset_state", 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    //    name          v  fn     z                      ovf sc ifn sup st bb  ec er  zf sf of  mv ve                     mc
    step("rst_e",       0, 2'b00, 64'h0,                 0,  0, 3,  0,  0, 0,  1, 0,  1, 0, 0,  0, 64'h0,                 0);
    step("rst_ne",      0, 2'b00, 64'h0,                 0,  0, 4,  0,  0, 0,  0, 0,  1, 0, 0,  0, 64'h0,                 0);
    step("add_ovf",     1, 2'b00, 64'h8000000000000000,  1,  1, 3,  0,  0, 0,  1, 0,  0, 1, 1,  1, 64'h8000000000000000,  1);
    step("ovf_l",       1, 2'b00, 64'h5,                 0,  0, 2,  0,  0, 0,  0, 0,  0, 1, 1,  1, 64'h5,                 0);
    step("ovf_ge",      1, 2'b00, 64'h6,                 0,  0, 5,  0,  0, 0,  1, 0,  0, 1, 1,  1, 64'h6,                 1);
    step("ovf_g",       1, 2'b00, 64'h7,                 0,  0, 6,  0,  0, 0,  1, 0,  0, 1, 1,  1, 64'h7,                 1);
    step("sub_zero",    1, 2'b01, 64'h0,                 0,  1, 1,  0,  0, 0,  0, 0,  1, 0, 0,  1, 64'h0,                 0);
    step("zero_le",     1, 2'b00, 64'h3,                 0,  0, 1,  0,  0, 0,  1, 0,  1, 0, 0,  1, 64'h3,                 1);
    step("zero_g",      1, 2'b00, 64'h4,                 0,  0, 6,  0,  0, 0,  0, 0,  1, 0, 0,  1, 64'h4,                 0);
    step("and_ovf",     1, 2'b10, 64'h1,                 1,  1, 4,  0,  0, 0,  0, 0,  0, 0, 0,  1, 64'h1,                 0);
    step("and_ne",      1, 2'b00, 64'h2,                 0,  0, 4,  0,  0, 0,  1, 0,  0, 0, 0,  1, 64'h2,                 1);
    step("xor_neg",     1, 2'b11, 64'hFFFFFFFFFFFFFFFF,  1,  1, 2,  0,  0, 0,  0, 0,  0, 1, 0,  1, 64'hFFFFFFFFFFFFFFFF,  0);
    step("xor_l",       1, 2'b00, 64'h8,                 0,  0, 2,  0,  0, 0,  1, 0,  0, 1, 0,  1, 64'h8,                 1);
    step("suppress",    1, 2'b01, 64'h0,                 0,  1, 0,  1,  0, 0,  1, 0,  0, 1, 0,  1, 64'h0,                 1);
    step("stall_bub1",  1, 2'b00, 64'h1234,              0,  1, 3,  0,  1, 1,  0, 0,  0, 1, 0,  1, 64'h0,                 1);
    step("stall_bub2",  1, 2'b00, 64'h55,                0,  1, 0,  0,  1, 1,  1, 0,  0, 1, 0,  1, 64'h0,                 1);
    step("bubble",      1, 2'b00, 64'h99,                0,  0, 0,  0,  0, 1,  1, 0,  0, 1, 0,  0, 64'h0,                 0);
    step("novalid_cc",  0, 2'b01, 64'h0,                 0,  1, 0,  0,  0, 0,  1, 0,  0, 1, 0,  0, 64'h0,                 0);
    step("bad_cond",    1, 2'b00, 64'h42,                0,  0, 9,  0,  0, 0,  0, 1,  0, 1, 0,  1, 64'h42,                0);
    step("bad_novalid", 0, 2'b00, 64'h43,                0,  0, 9,  0,  0, 0,  0, 0,  0, 1, 0,  0, 64'h43,                0);

    // Asynchronous reset asserted mid-cycle during a stall.
    drive(1'b1, 2'b00, 64'h77, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    push_full("async_rst", 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_ne", 0, 2'b00, 64'h0,                 0,  0, 4,  0,  0, 0,  0, 0,  1, 0, 0,  0, 64'h0,                 0);

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

endmodule
